// File: rtl/vmem_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : vmem_pkg                                                     |
// | Shared types and constants for the vector memory access sequencer.     |
// | Contents: vmem_state_t FSM encoding, default word/vector widths,       |
// |           WORDS / BEAT_W for the default geometry, idx_width() helper. |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
package vmem_pkg;

  localparam int DEF_N  = 32;
  localparam int DEF_V  = 256;
  localparam int WORDS  = DEF_V / DEF_N;
  localparam int BEAT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } vmem_state_t;

  // Beat index width for a given word count; never narrower than one bit.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vmem_rd_capture.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : vmem_rd_capture                                              |
// | Tracks outstanding read beats through a MEM_LAT-deep tag pipeline and  |
// | writes each returning memory word into its slot of the load register.  |
// | Ports   : clk, rst (async, active-high)                                |
// |           clr      - clear the assembled load data (new access)        |
// |           rd_en    - a read beat is issued this cycle                  |
// |           rd_idx   - beat index of the issued read                     |
// |           rd_word  - memory read word                                  |
// |           rdata    - assembled load data                               |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module vmem_rd_capture #(
  parameter int MEM_LAT = 1,
  parameter int N       = 32,
  parameter int V       = 256,
  parameter int IDX_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [N-1:0]     rd_word,
  output logic [V-1:0]     rdata
);

  logic [MEM_LAT-1:0]            tag_vld_q, tag_vld_d;
  logic [MEM_LAT-1:0][IDX_W-1:0] tag_idx_q, tag_idx_d;
  logic [V-1:0]                  rdata_q, rdata_d;

  // The pipeline advances every cycle independent of the global enable,
  // because the memory returns data a fixed time after the strobe.
  always_comb begin
    tag_vld_d    = '0;
    tag_idx_d    = '0;
    tag_vld_d[0] = rd_en;
    tag_idx_d[0] = rd_idx;
    for (int k = 1; k < MEM_LAT; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_idx_d[k] = tag_idx_q[k-1];
    end

    rdata_d = rdata_q;
    if (clr) begin
      rdata_d = '0;
    end else if (tag_vld_q[MEM_LAT-1]) begin
      // Tag at the pipeline exit lines up with the word now on rd_word.
      rdata_d[tag_idx_q[MEM_LAT-1]*N +: N] = rd_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld_q <= '0;
      tag_idx_q <= '0;
      rdata_q   <= '0;
    end else begin
      tag_vld_q <= tag_vld_d;
      tag_idx_q <= tag_idx_d;
      rdata_q   <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/vector_mem_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : vector_mem_unit                                              |
// | Memory-stage access sequencer: splits a V-bit vector load/store into   |
// | V/N single-word memory beats, passes scalar accesses as one beat, and  |
// | holds Busy so the pipeline stalls until the access completes.          |
// | Ports   : clk, rst (async, active-high), en                            |
// |           req_valid/req_we/req_vec/req_addr/req_wdata/req_byteen       |
// |           Busy, done, err, rdata                                       |
// |           AddressData, ByteenaData, WriteData, RdenData, WrenData,     |
// |           ReadData                                                     |
// | Config  : VMEM_ALIGN_CHECK_EN - misaligned requests complete at once   |
// |           with err=1; otherwise low address bits are forced to zero.   |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module vector_mem_unit
  import vmem_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int V       = DEF_V,
  parameter int MEM_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           req_valid,
  input  logic           req_we,
  input  logic           req_vec,
  input  logic [N-1:0]   req_addr,
  input  logic [V-1:0]   req_wdata,
  input  logic [N/8-1:0] req_byteen,
  output logic           Busy,
  output logic           done,
  output logic           err,
  output logic [V-1:0]   rdata,
  output logic [N-1:0]   AddressData,
  output logic [N/8-1:0] ByteenaData,
  output logic [N-1:0]   WriteData,
  output logic           RdenData,
  output logic           WrenData,
  input  logic [N-1:0]   ReadData
);

  localparam int NW    = V / N;
  localparam int BW    = idx_width(NW);
  localparam int BYTES = N / 8;
  localparam int DW    = $clog2(MEM_LAT + 1);

  localparam logic [N-1:0]  VEC_MASK    = N'(V / 8 - 1);
  localparam logic [N-1:0]  SCL_MASK    = N'(BYTES - 1);
  localparam logic [N-1:0]  BEAT_STRIDE = N'(BYTES);
  localparam logic [BW-1:0] LAST_VEC    = BW'(NW - 1);
  localparam logic [DW-1:0] DRAIN_LAST  = DW'(MEM_LAT - 1);

  vmem_state_t      state_q, state_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [N-1:0]     base_q, base_d;
  logic [V-1:0]     wdata_q, wdata_d;
  logic             we_q, we_d;
  logic             vec_q, vec_d;
  logic [BYTES-1:0] byteen_q, byteen_d;
  logic             err_q, err_d;
  logic [DW-1:0]    drain_q, drain_d;

  logic             accept;
  logic [BW-1:0]    last_beat;

  assign accept    = (state_q == IDLE) & req_valid & en;
  assign last_beat = vec_q ? LAST_VEC : '0;

`ifdef VMEM_ALIGN_CHECK_EN
  logic misalign;
  assign misalign = req_vec ? |(req_addr & VEC_MASK) : |(req_addr & SCL_MASK);
`endif

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    base_d   = base_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    vec_d    = vec_q;
    byteen_d = byteen_q;
    err_d    = err_q;
    drain_d  = drain_q;

    Busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    AddressData = '0;
    ByteenaData = '0;
    WriteData   = '0;
    RdenData    = 1'b0;
    WrenData    = 1'b0;

    case (state_q)
      IDLE: begin
        // Busy is combinational so the core stalls in the accept cycle.
        Busy = req_valid;
        if (accept) begin
          base_d   = req_addr & ~(req_vec ? VEC_MASK : SCL_MASK);
          wdata_d  = req_wdata;
          we_d     = req_we;
          vec_d    = req_vec;
          byteen_d = req_byteen;
          beat_d   = '0;
`ifdef VMEM_ALIGN_CHECK_EN
          err_d    = misalign;
          state_d  = misalign ? DONE : ISSUE;
`else
          err_d    = 1'b0;
          state_d  = ISSUE;
`endif
        end
      end

      ISSUE: begin
        Busy        = 1'b1;
        AddressData = base_q + N'(beat_q) * BEAT_STRIDE;
        ByteenaData = vec_q ? '1 : byteen_q;
        WriteData   = wdata_q[beat_q*N +: N];
        // A stalled beat keeps its address but must not touch memory.
        RdenData    = en & ~we_q;
        WrenData    = en & we_q;
        if (en) begin
          if (beat_q == last_beat) begin
            drain_d = '0;
            state_d = we_q ? DONE : DRAIN;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      DRAIN: begin
        // Covers the read latency of the final beat; ignores en.
        Busy = 1'b1;
        if (drain_q == DRAIN_LAST) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end

      DONE: begin
        // req_valid is still the completing instruction here; not re-accepted.
        done    = 1'b1;
        err     = err_q;
        err_d   = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      base_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      vec_q    <= 1'b0;
      byteen_q <= '0;
      err_q    <= 1'b0;
      drain_q  <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      base_q   <= base_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      vec_q    <= vec_d;
      byteen_q <= byteen_d;
      err_q    <= err_d;
      drain_q  <= drain_d;
    end
  end

  vmem_rd_capture #(
    .MEM_LAT (MEM_LAT),
    .N       (N),
    .V       (V),
    .IDX_W   (BW)
  ) u_rd_capture (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .rd_en   (RdenData),
    .rd_idx  (beat_q),
    .rd_word (ReadData),
    .rdata   (rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_vector_mem_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_vector_mem_unit                                           |
// | Self-checking bench for vector_mem_unit with a one-cycle-latency data  |
// | memory model and an expected-beat queue.                               |
// | Config  : honours VMEM_ALIGN_CHECK_EN in the alignment scenario.       |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_vector_mem_unit;

  localparam int N       = 32;
  localparam int V       = 256;
  localparam int MEM_LAT = 1;
  localparam int NB      = N / 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic           req_valid;
  logic           req_we;
  logic           req_vec;
  logic [N-1:0]   req_addr;
  logic [V-1:0]   req_wdata;
  logic [NB-1:0]  req_byteen;
  logic           Busy;
  logic           done;
  logic           err;
  logic [V-1:0]   rdata;
  logic [N-1:0]   AddressData;
  logic [NB-1:0]  ByteenaData;
  logic [N-1:0]   WriteData;
  logic           RdenData;
  logic           WrenData;
  logic [N-1:0]   ReadData;

  vector_mem_unit #(.N(N), .V(V), .MEM_LAT(MEM_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_vec     (req_vec),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_byteen  (req_byteen),
    .Busy        (Busy),
    .done        (done),
    .err         (err),
    .rdata       (rdata),
    .AddressData (AddressData),
    .ByteenaData (ByteenaData),
    .WriteData   (WriteData),
    .RdenData    (RdenData),
    .WrenData    (WrenData),
    .ReadData    (ReadData)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        we;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  // Data memory: 128 words; word i resets to 0x5A00_0000|i except
  // words at 0x100..0x11C which hold 0xA0+k.
  logic [31:0] mem [0:127];

  function automatic logic [31:0] init_word(input int i);
    if (i >= 64 && i < 72) return 32'h0000_00A0 + 32'(i - 64);
    return 32'h5A00_0000 | 32'(i);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ReadData <= '0;
      for (int i = 0; i < 128; i++) mem[i] <= init_word(i);
    end else begin
      // Junk when no read is pending, so a mistimed capture shows up.
      ReadData <= RdenData ? mem[AddressData[8:2]] : $urandom();
      if (WrenData) begin
        for (int b = 0; b < NB; b++)
          if (ByteenaData[b]) mem[AddressData[8:2]][b*8 +: 8] <= WriteData[b*8 +: 8];
      end
    end
  end

  task automatic drive_req(input logic we, input logic vec, input logic [31:0] addr,
                           input logic [V-1:0] wd, input logic [3:0] be);
    req_valid  = 1'b1;
    en         = 1'b1;
    req_we     = we;
    req_vec    = vec;
    req_addr   = addr;
    req_wdata  = wd;
    req_byteen = be;
  endtask

  task automatic push_beats(input logic we, input logic vec, input logic [31:0] addr,
                            input logic [V-1:0] wd, input logic [3:0] be);
    logic [31:0] base;
    beat_t       b;
    base = addr & ~(vec ? 32'h1F : 32'h3);
    for (int i = 0; i < (vec ? 8 : 1); i++) begin
      b.addr = base + 32'(4 * i);
      b.be   = vec ? 4'hF : be;
      b.wd   = wd[i*32 +: 32];
      b.we   = we;
      exp_q.push_back(b);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_vec = 1'b0;
    req_addr = '0; req_wdata = '0; req_byteen = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({Busy, done, err, rdata, AddressData, ByteenaData, WriteData, RdenData, WrenData} !== '0) begin
      n_err++; $display("FAIL reset_held: outputs not zero busy=%b done=%b rd=%b wr=%b", Busy, done, RdenData, WrenData);
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({Busy, done, err, rdata, RdenData, WrenData} !== '0) begin
      n_err++; $display("FAIL reset_release: busy=%b done=%b err=%b rdata=%h", Busy, done, err, rdata);
    end
  endtask

  task automatic test_vec_load;
    logic [V-1:0] exp_rd;
    beat_t        b;
    bit           got;
    exp_rd = '0;
    for (int k = 0; k < 8; k++) exp_rd[k*32 +: 32] = 32'h0000_00A0 + 32'(k);
    push_beats(1'b0, 1'b1, 32'h100, '0, 4'h0);
    @(posedge clk); #1;
    drive_req(1'b0, 1'b1, 32'h100, '0, 4'h0);
    @(negedge clk);
    n_vec++;
    if (Busy !== 1'b1) begin n_err++; $display("FAIL vl_accept_busy: got %b want 1", Busy); end
    got = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (RdenData || WrenData) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL vl_beat: unexpected strobe at addr %h", AddressData);
        end else begin
          b = exp_q.pop_front();
          if (AddressData !== b.addr || ByteenaData !== b.be || WrenData !== b.we || RdenData !== !b.we) begin
            n_err++; $display("FAIL vl_beat: got addr=%h be=%h wr=%b want addr=%h be=%h wr=%b",
                              AddressData, ByteenaData, WrenData, b.addr, b.be, b.we);
          end
        end
      end
      if (done) begin
        got = 1'b1;
        req_valid = 1'b0;
        n_vec++;
        if (c != 10) begin n_err++; $display("FAIL vl_latency: done at T+%0d want T+10", c); end
        n_vec++;
        if (rdata !== exp_rd) begin n_err++; $display("FAIL vl_rdata: got %h want %h", rdata, exp_rd); end
        n_vec++;
        if (err !== 1'b0 || Busy !== 1'b0) begin n_err++; $display("FAIL vl_done_flags: err=%b busy=%b want 0 0", err, Busy); end
      end else begin
        n_vec++;
        if (Busy !== 1'b1) begin n_err++; $display("FAIL vl_busy: got %b want 1 at T+%0d", Busy, c); end
      end
    end
    if (!got) begin n_vec++; n_err++; req_valid = 1'b0; $display("FAIL vl_timeout: done %b want 1", done); end
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL vl_beats_left: got %0d want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_vec_store;
    logic [V-1:0] wd;
    beat_t        b;
    bit           got;
    for (int k = 0; k < 8; k++) wd[k*32 +: 32] = 32'(k);
    push_beats(1'b1, 1'b1, 32'h40, wd, 4'h0);
    @(posedge clk); #1;
    drive_req(1'b1, 1'b1, 32'h40, wd, 4'h0);
    @(negedge clk);
    n_vec++;
    if (Busy !== 1'b1) begin n_err++; $display("FAIL vs_accept_busy: got %b want 1", Busy); end
    got = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (RdenData || WrenData) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL vs_beat: unexpected strobe at addr %h", AddressData);
        end else begin
          b = exp_q.pop_front();
          if (AddressData !== b.addr || ByteenaData !== b.be || WriteData !== b.wd || WrenData !== 1'b1 || RdenData !== 1'b0) begin
            n_err++; $display("FAIL vs_beat: got addr=%h be=%h wd=%h wr=%b want addr=%h be=%h wd=%h wr=1",
                              AddressData, ByteenaData, WriteData, WrenData, b.addr, b.be, b.wd);
          end
        end
      end
      if (done) begin
        got = 1'b1;
        req_valid = 1'b0;
        n_vec++;
        if (c != 9) begin n_err++; $display("FAIL vs_latency: done at T+%0d want T+9", c); end
        n_vec++;
        if (Busy !== 1'b0) begin n_err++; $display("FAIL vs_done_busy: got %b want 0", Busy); end
      end else begin
        n_vec++;
        if (Busy !== 1'b1) begin n_err++; $display("FAIL vs_busy: got %b want 1 at T+%0d", Busy, c); end
      end
    end
    if (!got) begin n_vec++; n_err++; req_valid = 1'b0; $display("FAIL vs_timeout: done %b want 1", done); end
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL vs_beats_left: got %0d want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_scalar_store;
    logic [V-1:0] wd;
    beat_t        b;
    bit           got;
    wd = {{(V-32){1'b0}}, 32'hDEAD_BEEF};
    push_beats(1'b1, 1'b0, 32'h8, wd, 4'b0011);
    @(posedge clk); #1;
    drive_req(1'b1, 1'b0, 32'h8, wd, 4'b0011);
    got = 1'b0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (RdenData || WrenData) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL ss_beat: unexpected strobe at addr %h", AddressData);
        end else begin
          b = exp_q.pop_front();
          if (AddressData !== b.addr || ByteenaData !== b.be || WriteData !== b.wd || WrenData !== 1'b1) begin
            n_err++; $display("FAIL ss_beat: got addr=%h be=%h wd=%h wr=%b want addr=%h be=%h wd=%h wr=1",
                              AddressData, ByteenaData, WriteData, WrenData, b.addr, b.be, b.wd);
          end
        end
      end
      if (done) begin
        got = 1'b1;
        req_valid = 1'b0;
        n_vec++;
        if (c != 2) begin n_err++; $display("FAIL ss_latency: done at T+%0d want T+2", c); end
      end
    end
    if (!got) begin n_vec++; n_err++; req_valid = 1'b0; $display("FAIL ss_timeout: done %b want 1", done); end
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL ss_beats_left: got %0d want 0", exp_q.size()); exp_q.delete(); end
  endtask

  // Reads back the word written by the scalar store: bytes 1:0 replaced.
  task automatic test_scalar_load;
    logic [V-1:0] exp_rd;
    beat_t        b;
    bit           got;
    exp_rd = {{(V-32){1'b0}}, 32'h5A00_BEEF};
    push_beats(1'b0, 1'b0, 32'h8, '0, 4'hF);
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 32'h8, '0, 4'hF);
    got = 1'b0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (RdenData || WrenData) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL sl_beat: unexpected strobe at addr %h", AddressData);
        end else begin
          b = exp_q.pop_front();
          if (AddressData !== b.addr || ByteenaData !== b.be || RdenData !== 1'b1) begin
            n_err++; $display("FAIL sl_beat: got addr=%h be=%h rd=%b want addr=%h be=%h rd=1",
                              AddressData, ByteenaData, RdenData, b.addr, b.be);
          end
        end
      end
      if (done) begin
        got = 1'b1;
        req_valid = 1'b0;
        n_vec++;
        if (c != 3) begin n_err++; $display("FAIL sl_latency: done at T+%0d want T+3", c); end
        n_vec++;
        if (rdata !== exp_rd) begin n_err++; $display("FAIL sl_rdata: got %h want %h", rdata, exp_rd); end
      end
    end
    if (!got) begin n_vec++; n_err++; req_valid = 1'b0; $display("FAIL sl_timeout: done %b want 1", done); end
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL sl_beats_left: got %0d want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_en_gap;
    logic [V-1:0] exp_rd;
    beat_t        b;
    bit           got;
    exp_rd = '0;
    for (int k = 0; k < 8; k++) exp_rd[k*32 +: 32] = 32'h0000_00A0 + 32'(k);
    push_beats(1'b0, 1'b1, 32'h100, '0, 4'h0);
    @(posedge clk); #1;
    drive_req(1'b0, 1'b1, 32'h100, '0, 4'h0);
    got = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(posedge clk); #1;
      en = (c == 5 || c == 6) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (c == 5 || c == 6) begin
        n_vec++;
        if (RdenData !== 1'b0 || WrenData !== 1'b0) begin
          n_err++; $display("FAIL eg_gap_strobe: got rd=%b wr=%b want 0 0 at T+%0d", RdenData, WrenData, c);
        end
      end
      if (RdenData || WrenData) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL eg_beat: unexpected strobe at addr %h", AddressData);
        end else begin
          b = exp_q.pop_front();
          if (AddressData !== b.addr || ByteenaData !== b.be || RdenData !== 1'b1) begin
            n_err++; $display("FAIL eg_beat: got addr=%h be=%h rd=%b want addr=%h be=%h rd=1",
                              AddressData, ByteenaData, RdenData, b.addr, b.be);
          end
        end
      end
      if (done) begin
        got = 1'b1;
        req_valid = 1'b0;
        n_vec++;
        if (c != 12) begin n_err++; $display("FAIL eg_latency: done at T+%0d want T+12", c); end
        n_vec++;
        if (rdata !== exp_rd) begin n_err++; $display("FAIL eg_rdata: got %h want %h", rdata, exp_rd); end
      end
    end
    en = 1'b1;
    if (!got) begin n_vec++; n_err++; req_valid = 1'b0; $display("FAIL eg_timeout: done %b want 1", done); end
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL eg_beats_left: got %0d want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    drive_req(1'b0, 1'b1, 32'h100, '0, 4'h0);
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
    end
    n_vec++;
    if (RdenData !== 1'b1 || AddressData !== 32'h114) begin
      n_err++; $display("FAIL rm_beat5: got rd=%b addr=%h want rd=1 addr=00000114", RdenData, AddressData);
    end
    #2;
    rst = 1'b1;
    req_valid = 1'b0;
    #1;
    n_vec++;
    if ({Busy, done, err, rdata, AddressData, ByteenaData, WriteData, RdenData, WrenData} !== '0) begin
      n_err++; $display("FAIL rm_async_clear: busy=%b rd=%b addr=%h rdata=%h want all 0", Busy, RdenData, AddressData, rdata);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    test_vec_load();
  endtask

  task automatic test_align;
    logic [V-1:0] exp_rd;
    beat_t        b;
    bit           got;
    int           exp_lat;
    logic         exp_err;
    exp_rd = '0;
`ifdef VMEM_ALIGN_CHECK_EN
    exp_lat = 1;
    exp_err = 1'b1;
`else
    for (int k = 0; k < 8; k++) exp_rd[k*32 +: 32] = 32'h0000_00A0 + 32'(k);
    exp_lat = 10;
    exp_err = 1'b0;
    push_beats(1'b0, 1'b1, 32'h104, '0, 4'h0);
`endif
    @(posedge clk); #1;
    drive_req(1'b0, 1'b1, 32'h104, '0, 4'h0);
    got = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (RdenData || WrenData) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL al_beat: unexpected strobe at addr %h", AddressData);
        end else begin
          b = exp_q.pop_front();
          if (AddressData !== b.addr || ByteenaData !== b.be || RdenData !== 1'b1) begin
            n_err++; $display("FAIL al_beat: got addr=%h be=%h rd=%b want addr=%h be=%h rd=1",
                              AddressData, ByteenaData, RdenData, b.addr, b.be);
          end
        end
      end
      if (done) begin
        got = 1'b1;
        req_valid = 1'b0;
        n_vec++;
        if (c != exp_lat) begin n_err++; $display("FAIL al_latency: done at T+%0d want T+%0d", c, exp_lat); end
        n_vec++;
        if (err !== exp_err) begin n_err++; $display("FAIL al_err: got %b want %b", err, exp_err); end
        n_vec++;
        if (rdata !== exp_rd) begin n_err++; $display("FAIL al_rdata: got %h want %h", rdata, exp_rd); end
      end
    end
    if (!got) begin n_vec++; n_err++; req_valid = 1'b0; $display("FAIL al_timeout: done %b want 1", done); end
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL al_beats_left: got %0d want 0", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_vec_load();
    test_vec_store();
    test_scalar_store();
    test_scalar_load();
    test_en_gap();
    test_reset_mid();
    test_align();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
